pc_fetch_ctrl: RTL and testbench

//  Parametrised program-counter and fetch-request controller for the CPU front end.

---
 rtl/pc_pkg.sv | 16 +
 rtl/redir_arbiter.sv | 27 ++
 rtl/pc_fetch_ctrl.sv | 136 +++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and channel indices for the fetch front end.
package pc_pkg;

   typedef enum logic [1:0] {
      S_BOOT,
      S_FETCH,
      S_WAIT,
      S_HALT
   } fetch_state_e;

   // Redirect channel indices; a lower index wins arbitration.
   localparam int unsigned REDIR_TRAP   = 0;
   localparam int unsigned REDIR_BRANCH = 1;
   localparam int unsigned REDIR_JUMP   = 2;

endpackage

// File: rtl/redir_arbiter.sv
// Fixed-priority redirect arbiter: the lowest asserted channel index wins.
module redir_arbiter #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_REDIR = 3
) (
   input  logic [NUM_REDIR-1:0]      valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] target_i,
   output logic                      any_valid_o,
   output logic [XLEN-1:0]           target_o,
   output logic [NUM_REDIR-1:0]      grant_o
);

   // Scan channels upward; the first valid one claims the grant.
   always_comb begin
      any_valid_o = 1'b0;
      target_o    = '0;
      grant_o     = '0;
      for (int k = 0; k < NUM_REDIR; k++) begin
         if (valid_i[k] && !any_valid_o) begin
            any_valid_o = 1'b1;
            grant_o[k]  = 1'b1;
            target_o    = target_i[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch request controller.
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = '0,
   parameter int unsigned     INC       = 4,
   parameter int unsigned     NUM_REDIR = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      stall_i,
   input  logic                      halt_i,
   input  logic [NUM_REDIR-1:0]      redir_valid_i,
   input  logic [NUM_REDIR*XLEN-1:0] redir_target_i,
   output logic                      im_req_o,
   output logic [XLEN-1:0]           im_addr_o,
   input  logic                      im_ready_i,
   output logic [XLEN-1:0]           pc_o,
   output logic                      halted_o,
   output logic                      misalign_o
);

   // INC is a power of two, so INC-1 covers exactly the bits that must be zero.
   // With INC=1 the mask is empty and misalignment can never be flagged.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

   fetch_state_e          state_q;
   logic [XLEN-1:0]       pc_q;
   logic                  pend_vld_q;
   logic [XLEN-1:0]       pend_pc_q;
   logic                  misalign_q;

   logic                  any_redir;
   logic [XLEN-1:0]       win_target;
   logic [NUM_REDIR-1:0]  grant;
   logic [NUM_REDIR-1:0]  ch_misalign;
   logic                  sel_misalign;
   logic [XLEN-1:0]       tgt_aligned;
   logic [XLEN-1:0]       pc_inc;

   redir_arbiter #(
      .XLEN      (XLEN),
      .NUM_REDIR (NUM_REDIR)
   ) u_redir_arbiter (
      .valid_i     (redir_valid_i),
      .target_i    (redir_target_i),
      .any_valid_o (any_redir),
      .target_o    (win_target),
      .grant_o     (grant)
   );

   // Per-channel low-bit check, then pick the granted channel's result.
   always_comb begin
      ch_misalign = '0;
      for (int k = 0; k < NUM_REDIR; k++) begin
         ch_misalign[k] = |(redir_target_i[k*XLEN +: XLEN] & ALIGN_MASK);
      end
      sel_misalign = |(grant & ch_misalign);
      tgt_aligned  = win_target & ~ALIGN_MASK;
      pc_inc       = pc_q + XLEN'(INC);
   end

   // Request valid; once raised in S_WAIT it cannot be retracted.
   always_comb begin
      im_req_o = 1'b0;
      unique case (state_q)
         S_FETCH: im_req_o = !stall_i && !halt_i && !any_redir;
         S_WAIT:  im_req_o = 1'b1;
         default: im_req_o = 1'b0;
      endcase
   end

   assign im_addr_o  = pc_q;
   assign pc_o       = pc_q;
   assign halted_o   = (state_q == S_HALT);
   assign misalign_o = misalign_q;

   // Fetch FSM with PC, pending-redirect and misalign registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_VEC;
         pend_vld_q <= 1'b0;
         pend_pc_q  <= '0;
         misalign_q <= 1'b0;
      end else begin
         // Any accepted redirect selection reports its alignment next cycle.
         misalign_q <= (state_q != S_BOOT) && sel_misalign;
         unique case (state_q)
            S_BOOT: begin
               state_q <= S_FETCH;
            end
            S_FETCH: begin
               if (any_redir) begin
                  pc_q <= tgt_aligned;
               end else if (halt_i) begin
                  state_q <= S_HALT;
               end else if (im_req_o) begin
                  if (im_ready_i) begin
                     pc_q <= pc_inc;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (im_ready_i) begin
                  if (any_redir) begin
                     pc_q <= tgt_aligned;
                  end else if (pend_vld_q) begin
                     pc_q <= pend_pc_q;
                  end else begin
                     pc_q <= pc_inc;
                  end
                  pend_vld_q <= 1'b0;
                  state_q    <= halt_i ? S_HALT : S_FETCH;
               end else if (any_redir) begin
                  // Address must stay stable; remember the newest redirect.
                  pend_vld_q <= 1'b1;
                  pend_pc_q  <= tgt_aligned;
               end
            end
            S_HALT: begin
               if (any_redir) begin
                  pc_q    <= tgt_aligned;
                  state_q <= S_FETCH;
               end else if (!halt_i) begin
                  state_q <= S_FETCH;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: accepted fetch addresses go through a scoreboard.
module tb_pc_fetch_ctrl;
   import pc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        halt;
   logic [2:0]  redir_valid;
   logic [95:0] redir_target;
   logic        im_req;
   logic [31:0] im_addr;
   logic        im_ready;
   logic [31:0] pc;
   logic        halted;
   logic        misalign;

   logic        reset16;
   logic [2:0]  redir_valid16;
   logic [47:0] redir_target16;
   logic        im_req16;
   logic [15:0] im_addr16;
   logic        im_ready16;
   logic [15:0] pc16;
   logic        halted16;
   logic        misalign16;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .XLEN      (32),
      .RESET_VEC (32'h0),
      .INC       (4),
      .NUM_REDIR (3)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .stall_i        (stall),
      .halt_i         (halt),
      .redir_valid_i  (redir_valid),
      .redir_target_i (redir_target),
      .im_req_o       (im_req),
      .im_addr_o      (im_addr),
      .im_ready_i     (im_ready),
      .pc_o           (pc),
      .halted_o       (halted),
      .misalign_o     (misalign)
   );

   pc_fetch_ctrl #(
      .XLEN      (16),
      .RESET_VEC (16'h0010),
      .INC       (2),
      .NUM_REDIR (3)
   ) dut16 (
      .clk            (clk),
      .reset          (reset16),
      .stall_i        (1'b0),
      .halt_i         (1'b0),
      .redir_valid_i  (redir_valid16),
      .redir_target_i (redir_target16),
      .im_req_o       (im_req16),
      .im_addr_o      (im_addr16),
      .im_ready_i     (im_ready16),
      .pc_o           (pc16),
      .halted_o       (halted16),
      .misalign_o     (misalign16)
   );

   // Scoreboard: every accepted request must match the oldest expected address.
   always @(negedge clk) begin
      if (!reset && im_req && im_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL accept_addr: got request at %h, expected none", im_addr);
         end else begin
            mon_exp = exp_q.pop_front();
            if (im_addr !== mon_exp) begin
               bad++;
               $display("FAIL accept_addr: got %h, expected %h", im_addr, mon_exp);
            end
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (pc !== 32'h0) begin
         bad++; $display("FAIL reset_pc: got %h, expected 0", pc);
      end
      total++;
      if (im_req !== 1'b0 || halted !== 1'b0 || misalign !== 1'b0) begin
         bad++;
         $display("FAIL reset_outs: got req=%b halted=%b mis=%b, expected 0 0 0",
                  im_req, halted, misalign);
      end
      @(posedge clk); #1;
      reset    = 1'b0;
      im_ready = 1'b1;
      @(negedge clk);
      total++;
      if (im_req !== 1'b0) begin
         bad++; $display("FAIL boot_bubble: got req=%b, expected 0", im_req);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int i = 0; i < 2; i++) begin
         a = 32'(i * 4);
         exp_q.push_back(a);
         @(negedge clk);
         total++;
         if (im_req !== 1'b1 || im_addr !== a) begin
            bad++;
            $display("FAIL b2b_issue: got req=%b addr=%h, expected 1 %h", im_req, im_addr, a);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_wait_hold();
      im_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         stall       = (i >= 1);
         redir_valid = '0;
         if (i == 1) begin
            redir_valid[REDIR_BRANCH]                = 1'b1;
            redir_target[REDIR_BRANCH*32 +: 32]      = 32'h100;
         end
         @(negedge clk);
         total++;
         if (im_req !== 1'b1 || im_addr !== 32'h8) begin
            bad++;
            $display("FAIL wait_hold: got req=%b addr=%h, expected 1 00000008", im_req, im_addr);
         end
         @(posedge clk); #1;
      end
      redir_valid = '0;
      stall       = 1'b0;
      im_ready    = 1'b1;
      exp_q.push_back(32'h8);
      @(posedge clk); #1;
      exp_q.push_back(32'h100);
      @(negedge clk);
      total++;
      if (im_req !== 1'b1 || im_addr !== 32'h100) begin
         bad++;
         $display("FAIL wait_redirect: got req=%b addr=%h, expected 1 00000100", im_req, im_addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_priority();
      redir_valid                        = 3'b101;
      redir_target[REDIR_TRAP*32 +: 32]  = 32'h80;
      redir_target[REDIR_JUMP*32 +: 32]  = 32'h200;
      @(negedge clk);
      total++;
      if (im_req !== 1'b0) begin
         bad++; $display("FAIL prio_bubble: got req=%b, expected 0", im_req);
      end
      @(posedge clk); #1;
      redir_valid = '0;
      exp_q.push_back(32'h80);
      @(negedge clk);
      total++;
      if (im_req !== 1'b1 || im_addr !== 32'h80 || misalign !== 1'b0) begin
         bad++;
         $display("FAIL prio_target: got req=%b addr=%h mis=%b, expected 1 00000080 0",
                  im_req, im_addr, misalign);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_misalign();
      redir_valid                          = '0;
      redir_valid[REDIR_BRANCH]            = 1'b1;
      redir_target[REDIR_BRANCH*32 +: 32]  = 32'h103;
      @(negedge clk);
      total++;
      if (im_req !== 1'b0) begin
         bad++; $display("FAIL misalign_bubble: got req=%b, expected 0", im_req);
      end
      @(posedge clk); #1;
      redir_valid = '0;
      stall       = 1'b1;
      @(negedge clk);
      total++;
      if (pc !== 32'h100 || misalign !== 1'b1) begin
         bad++;
         $display("FAIL misalign_pulse: got pc=%h mis=%b, expected 00000100 1", pc, misalign);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (misalign !== 1'b0) begin
         bad++; $display("FAIL misalign_width: got mis=%b, expected 0", misalign);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_halt();
      stall = 1'b0;
      halt  = 1'b1;
      @(negedge clk);
      total++;
      if (im_req !== 1'b0) begin
         bad++; $display("FAIL halt_noreq: got req=%b, expected 0", im_req);
      end
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (halted !== 1'b1 || im_req !== 1'b0 || pc !== 32'h100) begin
            bad++;
            $display("FAIL halt_state: got halted=%b req=%b pc=%h, expected 1 0 00000100",
                     halted, im_req, pc);
         end
         @(posedge clk); #1;
      end
      halt = 1'b0;
      @(posedge clk); #1;
      exp_q.push_back(32'h100);
      @(negedge clk);
      total++;
      if (halted !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h100) begin
         bad++;
         $display("FAIL halt_resume: got halted=%b req=%b addr=%h, expected 0 1 00000100",
                  halted, im_req, im_addr);
      end
      @(posedge clk); #1;
      halt = 1'b1;
      @(posedge clk); #1;
      redir_valid                          = '0;
      redir_valid[REDIR_BRANCH]            = 1'b1;
      redir_target[REDIR_BRANCH*32 +: 32]  = 32'h40;
      @(negedge clk);
      total++;
      if (halted !== 1'b1) begin
         bad++; $display("FAIL halt_second: got halted=%b, expected 1", halted);
      end
      @(posedge clk); #1;
      redir_valid = '0;
      halt        = 1'b0;
      exp_q.push_back(32'h40);
      @(negedge clk);
      total++;
      if (halted !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h40) begin
         bad++;
         $display("FAIL halt_redirect: got halted=%b req=%b addr=%h, expected 0 1 00000040",
                  halted, im_req, im_addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_in_wait();
      im_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (im_req !== 1'b1 || im_addr !== 32'h44) begin
         bad++;
         $display("FAIL wait_before_reset: got req=%b addr=%h, expected 1 00000044",
                  im_req, im_addr);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (im_req !== 1'b0 || pc !== 32'h0) begin
         bad++;
         $display("FAIL reset_abort: got req=%b pc=%h, expected 0 00000000", im_req, pc);
      end
      @(posedge clk); #1;
      stall = 1'b1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_wrap16();
      reset16    = 1'b0;
      im_ready16 = 1'b1;
      @(negedge clk);
      total++;
      if (pc16 !== 16'h0010 || im_req16 !== 1'b0) begin
         bad++;
         $display("FAIL wrap_resetvec: got pc=%h req=%b, expected 0010 0", pc16, im_req16);
      end
      @(posedge clk); #1;
      redir_valid16                  = 3'b010;
      redir_target16[16 +: 16]       = 16'hFFFE;
      @(posedge clk); #1;
      redir_valid16 = '0;
      @(negedge clk);
      total++;
      if (im_req16 !== 1'b1 || im_addr16 !== 16'hFFFE || misalign16 !== 1'b0) begin
         bad++;
         $display("FAIL wrap_top: got req=%b addr=%h mis=%b, expected 1 fffe 0",
                  im_req16, im_addr16, misalign16);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (im_req16 !== 1'b1 || im_addr16 !== 16'h0000 || halted16 !== 1'b0) begin
         bad++;
         $display("FAIL wrap_zero: got req=%b addr=%h halted=%b, expected 1 0000 0",
                  im_req16, im_addr16, halted16);
      end
      @(posedge clk); #1;
      reset16 = 1'b1;
   endtask

   initial begin
      reset          = 1'b1;
      stall          = 1'b0;
      halt           = 1'b0;
      redir_valid    = '0;
      redir_target   = '0;
      im_ready       = 1'b0;
      reset16        = 1'b1;
      redir_valid16  = '0;
      redir_target16 = '0;
      im_ready16     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_wait_hold();
      test_priority();
      test_misalign();
      test_halt();
      test_reset_in_wait();
      test_wrap16();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d unconsumed, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
